secant_meas_sequencer: RTL
==========================

Name: secant_meas_sequencer

Overview:
- Sequences the analog measurement loop behind the secant current controller.
- Takes the solver's i_ref, loads it into the DAC, waits a settling time, and runs NAVG ADC conversions.
- Averages the conversions and returns q_measured with a one-cycle ready strobe, then relaunches continuously while enabled.
- Raises a sticky timeout fault when the ADC stops answering.

Parameters:
- BUS_WIDTH, 10, width of i_ref, DAC code, ADC data and q_measured.
- SETTLE_CYCLES, 16, settle wait in clocks after dac_load; must be 1 or more.
- LOG2_NAVG, 2, log2 of conversions averaged per measurement (NAVG = 2**LOG2_NAVG).
- TIMEOUT_CYCLES, 255, maximum clocks spent waiting for adc_done.
- ITER_W, 8, width of meas_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run request; low aborts and idles the block.
- i_ref_in  in  BUS_WIDTH  reference code from the solver.
- adc_done  in  1  one-cycle pulse: adc_data is valid.
- adc_data  in  BUS_WIDTH  ADC conversion result.
- dac_code  out  BUS_WIDTH  code driven to the DAC.
- dac_load  out  1  one-cycle DAC latch strobe.
- adc_start  out  1  one-cycle conversion start strobe.
- q_measured  out  BUS_WIDTH  averaged measurement.
- ready  out  1  one-cycle strobe: q_measured updated.
- meas_count  out  ITER_W  published-measurement counter, saturating.
- timeout  out  1  sticky ADC timeout fault.
- busy  out  1  high in every state except IDLE and FAULT.

Behaviour:
- Reset values: all outputs are 0, state is IDLE, accumulator is 0.
- All outputs are registered.
- States: IDLE, LOAD, SETTLE, START, WAIT_DONE, PUBLISH, FAULT.
- IDLE: when enable is sampled high, go to LOAD.
- LOAD (1 cycle):
  - dac_code <= i_ref_in, dac_load = 1.
  - Clear accumulator and sample count.
  - Clear settle counter; go to SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES cycles, then go to START.
  - If i_ref_in != dac_code in any SETTLE cycle, go to LOAD; settling restarts with the new code.
- START (1 cycle): adc_start = 1, clear timeout counter, go to WAIT_DONE.
- WAIT_DONE:
  - On adc_done: accumulator += adc_data (width BUS_WIDTH+LOG2_NAVG, no overflow possible) and sample count increments.
  - If the sample count reaches NAVG, go to PUBLISH; otherwise go to START.
  - If no adc_done arrives, go to FAULT when the timeout counter reaches TIMEOUT_CYCLES.
  - If adc_done and timeout expiry coincide, adc_done wins.
- Reference change during conversion:
  - If i_ref_in != dac_code at any point in START or WAIT_DONE, a stale flag is set.
  - The in-flight conversion still completes, or times out.
  - On completion the flag is checked: if stale, discard the result, clear the flag and go to LOAD with no ready.
- PUBLISH (1 cycle):
  - q_measured <= accumulator >> LOG2_NAVG (truncating), ready = 1.
  - meas_count increments and saturates at 2**ITER_W-1.
  - Go to LOAD if enable is high, else IDLE.
  - Net effect: continuous measurement while enabled.
- FAULT:
  - timeout = 1; dac_load = adc_start = ready = 0.
  - Hold until enable is sampled low, then go to IDLE and clear timeout.
- enable low in any non-FAULT state:
  - Next state is IDLE; strobes are 0; accumulator and stale flag are cleared.
  - q_measured, dac_code and meas_count hold.
- adc_done outside WAIT_DONE is ignored.
- Latency:
  - dac_load is high the cycle after enable is first sampled high.
  - The first adc_start comes SETTLE_CYCLES+1 cycles after dac_load.
  - ready is high the cycle after the NAVG-th accepted adc_done.
- Reset asserted mid-operation: immediate return to reset values; strobes drop asynchronously.

Test Plan:
- Basic average. Set SETTLE_CYCLES=4, NAVG=4, the ADC model answering 3 cycles after adc_start with data 100, 101, 102, 105, and i_ref_in=300. Required: dac_code=300 with dac_load one cycle; first adc_start 5 cycles later; ready one cycle with q_measured=102; meas_count=1; next dac_load the following cycle.
- Settle restart. Change i_ref_in 300 -> 512 on the 2nd SETTLE cycle. Required: a second dac_load with dac_code=512; the adc_start gap is again 5 cycles from the new dac_load.
- Stale conversion. Change i_ref_in during WAIT_DONE. Required: the conversion completes, no ready is issued, a new LOAD happens with the new code, and meas_count is unchanged.
- Timeout. Never assert adc_done with TIMEOUT_CYCLES=10. Required: timeout=1 and busy=0 are held indefinitely; after an enable 1->0->1 sequence, timeout clears and dac_load re-issues.
- Boundaries. Use adc_data=1023 for all samples, and separately adc_done coinciding with the timeout-expiry cycle. Required: the first gives q_measured=1023 with no wrap; the second accepts the sample with no FAULT. Saturation check: run 300 measurements with ITER_W=8; meas_count stops at 255.
- Abort. Drop enable mid-WAIT_DONE, then assert rst low mid-SETTLE. Required: the enable drop gives IDLE next cycle with q_measured held and no ready; the rst assertion zeroes all outputs immediately.

Source files
------------

// File: rtl/secant_meas_sequencer.sv
// DAC-load / settle / ADC-average sequencer feeding measured current back to the secant solver.
// Relaunches continuously while enabled; a silent ADC latches a sticky timeout fault.
module secant_meas_sequencer #(
    parameter int unsigned BUS_WIDTH      = 10,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned LOG2_NAVG      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ITER_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] i_ref_in,
    input  logic                 adc_done,
    input  logic [BUS_WIDTH-1:0] adc_data,
    output logic [BUS_WIDTH-1:0] dac_code,
    output logic                 dac_load,
    output logic                 adc_start,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic [ITER_W-1:0]    meas_count,
    output logic                 timeout,
    output logic                 busy
);

    localparam int unsigned ACC_W  = BUS_WIDTH + LOG2_NAVG;
    localparam int unsigned NAVG   = 1 << LOG2_NAVG;
    localparam int unsigned SMP_W  = LOG2_NAVG + 1;
    localparam int unsigned SCNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_START,
        ST_WAIT_DONE,
        ST_PUBLISH,
        ST_FAULT
    } state_e;

    state_e              state_q;
    logic [ACC_W-1:0]    acc_q;
    logic [SMP_W-1:0]    smp_q;
    logic [SCNT_W-1:0]   settle_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                stale_q;

    logic                ref_changed_c;
    logic                last_smp_c;
    logic [ACC_W-1:0]    acc_sum_c;

    // Reference drift against the code currently latched in the DAC.
    assign ref_changed_c = (i_ref_in != dac_code);
    assign last_smp_c    = (smp_q == SMP_W'(NAVG - 1));
    assign acc_sum_c     = acc_q + ACC_W'(adc_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            smp_q      <= '0;
            settle_q   <= '0;
            tmo_q      <= '0;
            stale_q    <= 1'b0;
            dac_code   <= '0;
            dac_load   <= 1'b0;
            adc_start  <= 1'b0;
            q_measured <= '0;
            ready      <= 1'b0;
            meas_count <= '0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dac_load  <= 1'b0;
            adc_start <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;

            if (!enable && state_q != ST_FAULT) begin
                state_q <= ST_IDLE;
                acc_q   <= '0;
                stale_q <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q  <= ST_LOAD;
                        dac_code <= i_ref_in;
                        dac_load <= 1'b1;
                    end
                    ST_LOAD: begin
                        acc_q    <= '0;
                        smp_q    <= '0;
                        settle_q <= '0;
                        state_q  <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (ref_changed_c) begin
                            state_q  <= ST_LOAD;
                            dac_code <= i_ref_in;
                            dac_load <= 1'b1;
                        end else if (settle_q == SCNT_W'(SETTLE_CYCLES - 1)) begin
                            state_q   <= ST_START;
                            adc_start <= 1'b1;
                        end else begin
                            settle_q <= settle_q + SCNT_W'(1);
                        end
                    end
                    ST_START: begin
                        tmo_q   <= '0;
                        state_q <= ST_WAIT_DONE;
                        if (ref_changed_c) stale_q <= 1'b1;
                    end
                    ST_WAIT_DONE: begin
                        // A sample landing on the expiry cycle is still accepted.
                        if (adc_done) begin
                            if (stale_q || ref_changed_c) begin
                                stale_q  <= 1'b0;
                                state_q  <= ST_LOAD;
                                dac_code <= i_ref_in;
                                dac_load <= 1'b1;
                            end else begin
                                acc_q <= acc_sum_c;
                                smp_q <= smp_q + SMP_W'(1);
                                if (last_smp_c) begin
                                    state_q    <= ST_PUBLISH;
                                    q_measured <= acc_sum_c[ACC_W-1:LOG2_NAVG];
                                    ready      <= 1'b1;
                                    if (meas_count != {ITER_W{1'b1}})
                                        meas_count <= meas_count + ITER_W'(1);
                                end else begin
                                    state_q   <= ST_START;
                                    adc_start <= 1'b1;
                                end
                            end
                        end else begin
                            if (ref_changed_c) stale_q <= 1'b1;
                            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                                state_q <= ST_FAULT;
                                timeout <= 1'b1;
                                busy    <= 1'b0;
                            end else begin
                                tmo_q <= tmo_q + TMO_W'(1);
                            end
                        end
                    end
                    ST_PUBLISH: begin
                        state_q  <= ST_LOAD;
                        dac_code <= i_ref_in;
                        dac_load <= 1'b1;
                    end
                    ST_FAULT: begin
                        busy <= 1'b0;
                        if (!enable) begin
                            state_q <= ST_IDLE;
                            timeout <= 1'b0;
                            stale_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
